keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 matrix keypad and produces the key/key_valid stream consumed by
//   alarm_clock_top. It is the producer end of that interface.
//   Drives one row low at a time, samples the columns, and debounces press and release.
//   Emits exactly one key_valid pulse per debounced single-key press.
// PARAMETERS
//   SCAN_CYCLES      4  clocks each row is driven before its columns are sampled (>=3)
//   DEBOUNCE_CYCLES  8  consecutive stable samples required for press and for release (>=1)
// PORTS
//   clock      in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   col_n      in   4  keypad columns, active-low, pulled up, asynchronous
//   row_n      out  4  keypad row drive, active-low, exactly one bit low at all times
//   key        out  4  code of the last emitted key; holds until the next emit
//   key_valid  out  1  one-cycle pulse: key is new
// BEHAVIOUR
//   - Key map, row r / col c:
//       r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: * 0 # D
//     Codes: digits = their value, A..D = 0xA..0xD, *=0xE, #=0xF.
//   - col_n passes through a 2-flop synchroniser (col_s); sync flops reset to 4'b1111.
//   - Reset values: row_n=4'b1110 (row0), key=0, key_valid=0, state=SCAN, all counters 0.
//   - SCAN:
//     - scan_cnt counts 0..SCAN_CYCLES-1 with the current row held.
//     - At scan_cnt==SCAN_CYCLES-1, sample col_s:
//       - any bit low: latch row index and col_s pattern, deb_cnt=0, go to DEBOUNCE; row_n unchanged.
//       - all high: advance to the next row (3 wraps to 0), scan_cnt=0.
//   - DEBOUNCE:
//     - Each cycle, compare col_s with the latched pattern.
//     - Mismatch: go to SCAN on the next row, scan_cnt=0, no emit.
//     - DEBOUNCE_CYCLES consecutive matches, exactly one bit low: go to EMIT.
//     - DEBOUNCE_CYCLES consecutive matches, more than one bit low (ghost/multi-key): go to RELEASE, no emit.
//   - EMIT: key=mapped code and key_valid=1 for exactly one cycle, then go to RELEASE.
//   - RELEASE:
//     - Row held.
//     - Requires col_s==4'b1111 for DEBOUNCE_CYCLES consecutive cycles; any low bit restarts the count.
//     - Then go to SCAN on the next row, scan_cnt=0.
//   - Held keys never auto-repeat. A second key pressed while the first is held is ignored until all are released.
//   - Press on a row other than the one being driven is not seen until that row is scanned.
//   - Latency with a key stable from reset (row0 key):
//     - Cycle 0 = first edge with reset low.
//     - Sample at cycle SCAN_CYCLES-1.
//     - key_valid high during cycle SCAN_CYCLES+DEBOUNCE_CYCLES (12 at defaults).
//   - Worst-case detect delay after a stable press: 4*SCAN_CYCLES+2 cycles, plus DEBOUNCE_CYCLES+1 to key_valid.
//   - Reset mid-operation (any state, including EMIT):
//     - Next cycle equals the reset values; no key_valid pulse is produced.
//     - key returns to 0.
//   - Counters sized $clog2(max(param,2)); no overflow; counters saturate-free by state exit.
// TESTING
//   - Keypad model: col_n[c]=0 iff row_n[r]==0 and key (r,c) is pressed.
//   - Scenarios:
//     - Reset held 3 cycles -> row_n=4'b1110, key=0, key_valid=0. No key -> row_n rotates 1110,1101,1011,0111, each for 4 cycles.
//     - Press '9' (r2,c2) and hold 200 cycles -> exactly one key_valid with key=4'd9; key stays 9 after the pulse.
//     - Press '1' bouncing (toggle every cycle for 5 cycles) then stable -> exactly one pulse, key=1. Bouncing release -> no extra pulse.
//     - Press '1' and '2' together (r0: col_n=4'b1100) -> no key_valid; after release, scanning resumes at row1.
//     - Sequence '2','3','5','9', each pressed 40 cycles then released 40 -> four pulses, keys 2,3,5,9 in order.
//       Wiring to alarm_clock_top with time_button pulsed first sets 23:59.
//     - Assert reset during DEBOUNCE of '5' -> no pulse, row_n=4'b1110 next cycle, key=0.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low row across the keypad, debounces press and
// release, and emits one key/key_valid pulse per debounced single-key press.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int unsigned SCW = $clog2(SCAN_CYCLES > 2 ? SCAN_CYCLES : 2);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES > 2 ? DEBOUNCE_CYCLES : 2);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  state_t         state_q;
  logic [3:0]     col_m_q, col_s_q;
  logic [1:0]     row_q;
  logic [3:0]     row_n_q;
  logic [SCW-1:0] scan_cnt_q;
  logic [DBW-1:0] deb_cnt_q;
  logic [3:0]     pat_q;
  logic [3:0]     key_q;
  logic           key_valid_q;

  logic [1:0]     row_d;
  logic [3:0]     row_n_d;
  logic [1:0]     col_idx_d;
  logic [3:0]     key_code_d;
  logic           single_low_d;

  always_comb begin
    row_d        = row_q + 2'd1;
    row_n_d      = ~(4'b0001 << row_d);
    single_low_d = ($countones(pat_q) == 3);
    col_idx_d    = 2'd0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!pat_q[c]) col_idx_d = 2'(c);
    end
    case ({row_q, col_idx_d})
      4'd0:    key_code_d = 4'h1;
      4'd1:    key_code_d = 4'h2;
      4'd2:    key_code_d = 4'h3;
      4'd3:    key_code_d = 4'hA;
      4'd4:    key_code_d = 4'h4;
      4'd5:    key_code_d = 4'h5;
      4'd6:    key_code_d = 4'h6;
      4'd7:    key_code_d = 4'hB;
      4'd8:    key_code_d = 4'h7;
      4'd9:    key_code_d = 4'h8;
      4'd10:   key_code_d = 4'h9;
      4'd11:   key_code_d = 4'hC;
      4'd12:   key_code_d = 4'hE;
      4'd13:   key_code_d = 4'h0;
      4'd14:   key_code_d = 4'hF;
      default: key_code_d = 4'hD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SCAN;
      col_m_q     <= '1;
      col_s_q     <= '1;
      row_q       <= '0;
      row_n_q     <= 4'b1110;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      pat_q       <= '1;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      col_m_q     <= col_n;
      col_s_q     <= col_m_q;
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (col_s_q != '1) begin
              pat_q     <= col_s_q;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q   <= row_d;
              row_n_q <= row_n_d;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + SCW'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s_q != pat_q) begin
            row_q      <= row_d;
            row_n_q    <= row_n_d;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            // multi-key patterns skip EMIT but still wait for a full release
            deb_cnt_q <= '0;
            state_q   <= single_low_d ? EMIT : RELEASE;
          end else begin
            deb_cnt_q <= deb_cnt_q + DBW'(1);
          end
        end
        EMIT: begin
          key_q       <= key_code_d;
          key_valid_q <= 1'b1;
          deb_cnt_q   <= '0;
          state_q     <= RELEASE;
        end
        RELEASE: begin
          if (col_s_q != '1) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q  <= '0;
            row_q      <= row_d;
            row_n_q    <= row_n_d;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + DBW'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_n     = row_n_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model, expected-key scoreboard and
// per-cycle invariant checks, plus literal timing/value checks per scenario.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_n, row_n, key;
  logic       key_valid;
  logic [15:0] pressed;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned npulse  = 0;
  logic [3:0]  exp_q[$];

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clock    (clk),
    .reset    (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key),
    .key_valid(key_valid)
  );

  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] code_of(input int r, input int c);
    return kmap[r*4+c];
  endfunction

  logic [3:0] prev_key;
  logic       prev_kv;
  always @(negedge clk) begin
    if (rst) begin
      prev_key = key;
      prev_kv  = key_valid;
    end else begin
      chk("row_onehot", $countones(~row_n), 1);
      if (key_valid) begin
        npulse++;
        chk("pulse_width", prev_kv, 0);
        chk("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("pulse_key", key, exp_q.pop_front());
      end else begin
        chk("key_hold", key, prev_key);
      end
      prev_key = key;
      prev_kv  = key_valid;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          first;
    int unsigned base;
    int          seq_r [4] = '{0, 0, 1, 2};
    int          seq_c [4] = '{1, 2, 1, 2};

    rst = 1'b1;
    pressed = '0;
    cycles(3);
    chk("reset_row", row_n, 4'b1110);
    chk("reset_key", key, 4'd0);
    chk("reset_kv", key_valid, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycles(1);
      chk("rotate", row_n, rows[((k + 1) / 4) % 4]);
    end

    // '1' held through reset: pulse exactly 12 cycles after reset release
    rst = 1'b1;
    pressed[0] = 1'b1;
    exp_q.push_back(code_of(0, 0));
    cycles(3);
    rst = 1'b0;
    first = -1;
    for (int k = 0; k < 40; k++) begin
      cycles(1);
      if (key_valid && first < 0) first = k;
    end
    chk("latency", first, 12);
    chk("latency_key", key, 4'd1);
    pressed = '0;
    cycles(60);

    base = npulse;
    pressed[2*4+2] = 1'b1;
    exp_q.push_back(code_of(2, 2));
    cycles(200);
    chk("nine_pulses", npulse - base, 1);
    chk("nine_key", key, 4'd9);
    pressed = '0;
    cycles(60);

    base = npulse;
    exp_q.push_back(code_of(0, 0));
    for (int i = 0; i < 5; i++) begin
      pressed[0] = ~pressed[0];
      cycles(1);
    end
    cycles(100);
    chk("bounce_press_pulses", npulse - base, 1);
    chk("bounce_key", key, 4'd1);
    for (int i = 0; i < 5; i++) begin
      pressed[0] = ~pressed[0];
      cycles(1);
    end
    cycles(100);
    chk("bounce_release_pulses", npulse - base, 1);

    base = npulse;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    cycles(150);
    chk("multi_no_pulse", npulse - base, 0);
    chk("multi_row_held", row_n, 4'b1110);
    pressed = '0;
    for (int t = 0; t < 50 && row_n == 4'b1110; t++) cycles(1);
    chk("multi_resume_row", row_n, 4'b1101);
    cycles(40);

    base = npulse;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(code_of(seq_r[i], seq_c[i]));
      pressed[seq_r[i]*4+seq_c[i]] = 1'b1;
      cycles(40);
      pressed = '0;
      cycles(40);
    end
    chk("seq_pulses", npulse - base, 4);
    chk("seq_last_key", key, 4'd9);

    // '5' held through reset is in debounce 10 cycles after release
    rst = 1'b1;
    pressed[1*4+1] = 1'b1;
    cycles(3);
    chk("pre_key_cleared", key, 4'd0);
    rst = 1'b0;
    cycles(10);
    chk("deb5_row", row_n, 4'b1101);
    chk("deb5_kv", key_valid, 1'b0);
    rst = 1'b1;
    pressed = '0;
    cycles(1);
    chk("midreset_row", row_n, 4'b1110);
    chk("midreset_key", key, 4'd0);
    chk("midreset_kv", key_valid, 1'b0);
    rst = 1'b0;
    base = npulse;
    cycles(50);
    chk("midreset_no_pulse", npulse - base, 0);
    chk("midreset_key_after", key, 4'd0);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
